l2_dual_port_arbiter: RTL and testbench
=======================================

Name: l2_dual_port_arbiter

Overview:
- Shares the dual-port L2 memory between NumReq on-chip masters, e.g. host, safety island, mailbox and DMA.
- Decodes each request address to L2 port 0 (base 0x7800_0000, 2 MiB) or port 1 (0x7820_0000, 2 MiB).
- Runs an independent round-robin arbiter per port, with at most one outstanding transaction per port.
- Answers out-of-range addresses locally with an error response. Sits between the AXI-to-mem converters and the two L2 bank ports.

Parameters:
- NumReq, 4, number of requesting masters (2..8).
- AddrWidth, 64, request address width.
- DataWidth, 64, data width.
- L2Port0Base, 64'h7800_0000, port 0 base address.
- L2PortSize, 64'h0020_0000, size of each port; port 1 base = L2Port0Base + L2PortSize.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  NumReq  request valid per master
- req_ready_o  out  NumReq  request accepted
- req_addr_i  in  NumReq*AddrWidth  byte address
- req_we_i  in  NumReq  write enable
- req_wdata_i  in  NumReq*DataWidth  write data
- rsp_valid_o  out  NumReq  response valid, single-cycle pulse
- rsp_rdata_o  out  NumReq*DataWidth  read data
- rsp_err_o  out  NumReq  decode error
- l2_req_o  out  2  request to port p
- l2_gnt_i  in  2  port p accepts request
- l2_addr_o  out  2*AddrWidth  port-relative offset (addr − port base)
- l2_we_o  out  2  write enable
- l2_wdata_o  out  2*DataWidth  write data
- l2_rvalid_i  in  2  port p response
- l2_rdata_i  in  2*DataWidth  port p read data

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk_i, rst_i).
- Reset values:
  - All outputs 0.
  - Both port FSMs in IDLE.
  - Round-robin pointers = 0.
  - Error-response registers clear.
- Decode (combinational) per master:
  - PORT0 if L2Port0Base <= addr < L2Port0Base + L2PortSize.
  - PORT1 if the address lies in the next L2PortSize window.
  - Otherwise ERR.
  - Comparisons are full AddrWidth unsigned; no wrap.
- Per-port FSM, IDLE / REQ / WAIT:
  - IDLE: if any master has valid with a matching decode, pick a winner by round-robin starting at rr_ptr. Latch winner id, offset, we and wdata; go to REQ on the next cycle.
  - REQ: drive l2_req_o=1 with the latched fields. On l2_gnt_i: pulse req_ready_o[winner] in the same cycle, go to WAIT.
  - WAIT: on l2_rvalid_i, assert rsp_valid_o[winner] for 1 cycle with rdata (writes also get a response, rdata=0). Set rr_ptr = winner+1 mod NumReq; return to IDLE.
- Masters must hold valid and fields stable until ready; ready never asserts without valid.
- Minimum latency: request valid at cycle 0 → l2_req_o at cycle 1 → ready at grant → response the cycle after l2_rvalid_i (registered).
- ERR path:
  - Accepted in 1 cycle (req_ready_o pulse).
  - Next cycle: rsp_valid_o=1, rsp_err_o=1, rdata=0.
  - Does not involve a port.
- Per-master ordering: a master granted on one port is masked from both arbiters until its response returns. This guarantees in-order responses.
- Simultaneous events:
  - The two ports may complete in the same cycle for different masters; both responses are issued.
  - If a master's ERR response and a port response coincide, that cannot happen for the same master, because it is masked.
- l2_rvalid_i in IDLE or REQ is ignored. Nothing is flagged unless the optional feature is built in.
- Reset mid-transaction: the FSM returns to IDLE and the pending response is dropped; the L2 side is reset together with this block.

Optional Feature:
- L2_ARB_PERF_CNT_EN defined:
  - Adds outputs perf_grant_cnt_o (2*32 bits), one per-port count of granted transactions, saturating at 32'hFFFF_FFFF.
  - Adds output perf_err_cnt_o (32 bits), counting decode errors plus stray rvalids, also saturating.
  - Counters reset to 0.
- Undefined: these ports and counters are absent; stray rvalid is silently ignored.

Test Plan:
- Master 0 reads 0x7800_0010, port 0 gnt immediate, rvalid 2 cycles later with data 0xDEAD → l2_addr_o[0]=0x10; rsp_valid_o[0] with rdata 0xDEAD; port 1 idle.
- Master 1 writes 0x7820_0008, and in the same cycle master 2 reads 0x7800_0000 → both ports active in parallel; l2_addr_o[1]=0x8; both responses returned.
- Masters 0–3 all hammer port 0 continuously → grant order 0,1,2,3,0; no master is granted twice before the others are served.
- Master 3 accesses 0x7840_0000, and separately 0x77FF_FFF8 → ready pulse, then next cycle rsp_err_o[3]=1, rdata=0; no l2_req_o.
- Assert rst_i while port 1 is in WAIT → all outputs 0 immediately; a later l2_rvalid_i[1] produces no response.
- With L2_ARB_PERF_CNT_EN: 5 port 0 grants and 2 decode errors → perf_grant_cnt_o[0]=5, perf_err_cnt_o=2.

Source files
------------

// File: rtl/l2_dual_port_arbiter.sv
// Arbitrates NumReq masters onto the two L2 bank ports, one round-robin arbiter per port.
// Optional L2_ARB_PERF_CNT_EN adds saturating grant and error counters.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transaction on this port; pick a winner when one is eligible
// REQ    | l2_req_o high with latched fields, waiting for l2_gnt_i
// WAIT   | granted, waiting for l2_rvalid_i to return the response
module l2_dual_port_arbiter #(
    parameter int unsigned          NumReq      = 4,
    parameter int unsigned          AddrWidth   = 64,
    parameter int unsigned          DataWidth   = 64,
    parameter logic [AddrWidth-1:0] L2Port0Base = AddrWidth'(64'h7800_0000),
    parameter logic [AddrWidth-1:0] L2PortSize  = AddrWidth'(64'h0020_0000)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NumReq-1:0]         req_valid_i,
    output logic [NumReq-1:0]         req_ready_o,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    input  logic [NumReq-1:0]         req_we_i,
    input  logic [NumReq*DataWidth-1:0] req_wdata_i,
    output logic [NumReq-1:0]         rsp_valid_o,
    output logic [NumReq*DataWidth-1:0] rsp_rdata_o,
    output logic [NumReq-1:0]         rsp_err_o,
    output logic [1:0]                l2_req_o,
    input  logic [1:0]                l2_gnt_i,
    output logic [2*AddrWidth-1:0]    l2_addr_o,
    output logic [1:0]                l2_we_o,
    output logic [2*DataWidth-1:0]    l2_wdata_o,
    input  logic [1:0]                l2_rvalid_i,
    input  logic [2*DataWidth-1:0]    l2_rdata_i
`ifdef L2_ARB_PERF_CNT_EN
    ,
    output logic [63:0]               perf_grant_cnt_o,
    output logic [31:0]               perf_err_cnt_o
`endif
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [AddrWidth-1:0] P1Base = L2Port0Base + L2PortSize;
    localparam logic [AddrWidth-1:0] P1End  = P1Base + L2PortSize;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                       state_q [2];
    state_e                       state_d [2];
    logic [1:0][IdxW-1:0]         win_q, win_d, rr_q, rr_d;
    logic [1:0][AddrWidth-1:0]    off_q, off_d;
    logic [1:0][DataWidth-1:0]    wdata_q, wdata_d;
    logic [1:0]                   we_q, we_d;
    logic [NumReq-1:0]            err_acc_q, err_acc_d;
    logic [NumReq-1:0]            rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [NumReq*DataWidth-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [NumReq-1:0]            dec_p0, dec_p1, dec_err, busy;
    logic [1:0][NumReq-1:0]       elig;
    logic [IdxW-1:0]              sel;

    function automatic logic [IdxW-1:0] rr_pick(input logic [NumReq-1:0] cand,
                                                input logic [IdxW-1:0] ptr);
        logic [IdxW-1:0] pick;
        int unsigned     idx;
        pick = '0;
        // Walk backwards so the first eligible index at or after ptr wins.
        for (int i = NumReq - 1; i >= 0; i--) begin
            idx = 32'(ptr) + 32'(i);
            if (idx >= NumReq) idx = idx - NumReq;
            if (cand[idx]) pick = IdxW'(idx);
        end
        return pick;
    endfunction

    for (genvar m = 0; m < NumReq; m++) begin : g_dec
        logic [AddrWidth-1:0] addr;
        assign addr       = req_addr_i[m*AddrWidth +: AddrWidth];
        assign dec_p0[m]  = (addr >= L2Port0Base) && (addr < P1Base);
        assign dec_p1[m]  = (addr >= P1Base) && (addr < P1End);
        assign dec_err[m] = ~(dec_p0[m] | dec_p1[m]);
    end

    // A master with a transaction in flight anywhere is kept out of both arbiters.
    always_comb begin
        busy = err_acc_q;
        for (int p = 0; p < 2; p++) begin
            if (state_q[p] != ST_IDLE) busy[win_q[p]] = 1'b1;
        end
    end

    assign elig[0] = req_valid_i & dec_p0 & ~busy;
    assign elig[1] = req_valid_i & dec_p1 & ~busy;

    always_comb begin
        err_acc_d   = req_valid_i & dec_err & ~busy;
        req_ready_o = err_acc_q;
        rsp_valid_d = err_acc_q;
        rsp_err_d   = err_acc_q;
        rsp_rdata_d = '0;
        sel         = '0;
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            win_d[p]   = win_q[p];
            rr_d[p]    = rr_q[p];
            off_d[p]   = off_q[p];
            we_d[p]    = we_q[p];
            wdata_d[p] = wdata_q[p];
            case (state_q[p])
                ST_IDLE: begin
                    if (|elig[p]) begin
                        sel        = rr_pick(elig[p], rr_q[p]);
                        win_d[p]   = sel;
                        off_d[p]   = req_addr_i[sel*AddrWidth +: AddrWidth]
                                     - ((p == 0) ? L2Port0Base : P1Base);
                        we_d[p]    = req_we_i[sel];
                        wdata_d[p] = req_wdata_i[sel*DataWidth +: DataWidth];
                        state_d[p] = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (l2_gnt_i[p]) begin
                        req_ready_o[win_q[p]] = 1'b1;
                        state_d[p]            = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (l2_rvalid_i[p]) begin
                        rsp_valid_d[win_q[p]] = 1'b1;
                        rsp_rdata_d[win_q[p]*DataWidth +: DataWidth] =
                            we_q[p] ? '0 : l2_rdata_i[p*DataWidth +: DataWidth];
                        rr_d[p]    = (win_q[p] == IdxW'(NumReq - 1)) ? '0 : win_q[p] + 1'b1;
                        state_d[p] = ST_IDLE;
                    end
                end
                default: state_d[p] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= ST_IDLE;
            end
            win_q       <= '0;
            rr_q        <= '0;
            off_q       <= '0;
            we_q        <= '0;
            wdata_q     <= '0;
            err_acc_q   <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            rsp_rdata_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                state_q[p] <= state_d[p];
            end
            win_q       <= win_d;
            rr_q        <= rr_d;
            off_q       <= off_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            err_acc_q   <= err_acc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

    // Port fields are only driven while a request is presented.
    always_comb begin
        l2_req_o   = '0;
        l2_we_o    = '0;
        l2_addr_o  = '0;
        l2_wdata_o = '0;
        for (int p = 0; p < 2; p++) begin
            if (state_q[p] == ST_REQ) begin
                l2_req_o[p]                            = 1'b1;
                l2_we_o[p]                             = we_q[p];
                l2_addr_o[p*AddrWidth +: AddrWidth]    = off_q[p];
                l2_wdata_o[p*DataWidth +: DataWidth]   = wdata_q[p];
            end
        end
    end

`ifdef L2_ARB_PERF_CNT_EN
    logic [1:0][31:0] grant_cnt_q;
    logic [31:0]      err_cnt_q;
    logic [4:0]       err_inc;
    logic [32:0]      err_sum;

    // Decode errors are counted on their acceptance pulse; stray rvalids outside WAIT add to the same count.
    always_comb begin
        err_inc = '0;
        for (int m = 0; m < NumReq; m++) begin
            err_inc = err_inc + 5'(err_acc_q[m]);
        end
        for (int p = 0; p < 2; p++) begin
            if (l2_rvalid_i[p] && (state_q[p] != ST_WAIT)) err_inc = err_inc + 5'd1;
        end
        err_sum = {1'b0, err_cnt_q} + 33'(err_inc);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if ((state_q[p] == ST_REQ) && l2_gnt_i[p] && (grant_cnt_q[p] != '1)) begin
                    grant_cnt_q[p] <= grant_cnt_q[p] + 32'd1;
                end
            end
            err_cnt_q <= err_sum[32] ? '1 : err_sum[31:0];
        end
    end

    assign perf_grant_cnt_o = grant_cnt_q;
    assign perf_err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_l2_dual_port_arbiter.sv
// Self-checking bench for l2_dual_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of decode, routing and per-master ordering.
module tb_l2_dual_port_arbiter;

    localparam logic [63:0] P0   = 64'h7800_0000;
    localparam logic [63:0] SZ   = 64'h0020_0000;
    localparam logic [63:0] P1   = P0 + SZ;
    localparam logic [63:0] PEND = P1 + SZ;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic [3:0]   req_valid_i, req_ready_o, req_we_i;
    logic [255:0] req_addr_i, req_wdata_i;
    logic [3:0]   rsp_valid_o, rsp_err_o;
    logic [255:0] rsp_rdata_o;
    logic [1:0]   l2_req_o, l2_gnt_i, l2_we_o, l2_rvalid_i;
    logic [127:0] l2_addr_o, l2_wdata_o, l2_rdata_i;
`ifdef L2_ARB_PERF_CNT_EN
    logic [63:0]  perf_grant_cnt_o;
    logic [31:0]  perf_err_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;
    bit auto_pend;

    l2_dual_port_arbiter dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_we_i    (req_we_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .l2_req_o    (l2_req_o),
        .l2_gnt_i    (l2_gnt_i),
        .l2_addr_o   (l2_addr_o),
        .l2_we_o     (l2_we_o),
        .l2_wdata_o  (l2_wdata_o),
        .l2_rvalid_i (l2_rvalid_i),
        .l2_rdata_i  (l2_rdata_i)
`ifdef L2_ARB_PERF_CNT_EN
        ,
        .perf_grant_cnt_o (perf_grant_cnt_o),
        .perf_err_cnt_o   (perf_err_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic int decode(input logic [63:0] a);
        if (a >= P0 && a < P0 + SZ) return 0;
        if (a >= P0 + SZ && a < P0 + 2 * SZ) return 1;
        return 2;
    endfunction

    function automatic logic [63:0] l2_word(input int p, input logic [63:0] off);
        return {32'(p + 1) ^ 32'hA5A5_0000, off[31:0] ^ 32'h1357_9BDF};
    endfunction

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid_i = '0;
        req_we_i    = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        l2_gnt_i    = '0;
        l2_rvalid_i = '0;
        l2_rdata_i  = '0;
        auto_pend   = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
    endtask

    task automatic set_req(input int m, input logic [63:0] addr, input logic we, input logic [63:0] wd);
        req_valid_i[m]           = 1'b1;
        req_addr_i[m*64 +: 64]   = addr;
        req_we_i[m]              = we;
        req_wdata_i[m*64 +: 64]  = wd;
    endtask

    // Port 0 model that grants immediately and answers one cycle after the grant.
    task automatic auto_step();
        cyc();
        l2_rvalid_i[0] = auto_pend;
        auto_pend      = 1'b0;
        l2_gnt_i[0]    = l2_req_o[0];
        #1;
        if (l2_gnt_i[0]) auto_pend = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_inputs();
        #3;
        checks++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, l2_req_o, l2_we_o} !== 14'd0) begin
            failures++;
            $display("FAIL reset_ctrl: got %h expected 0", {req_ready_o, rsp_valid_o, rsp_err_o, l2_req_o, l2_we_o});
        end
        checks++;
        if ({rsp_rdata_o, l2_addr_o, l2_wdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_data: got nonzero rdata/addr/wdata expected 0");
        end
        do_reset();
        cyc();
        checks++;
        if (l2_req_o !== 2'b00 || rsp_valid_o !== 4'd0) begin
            failures++;
            $display("FAIL idle_after_reset: l2_req=%b rsp_valid=%b expected 0", l2_req_o, rsp_valid_o);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        set_req(0, 64'h7800_0010, 1'b0, 64'd0);
        #1;
        checks++;
        if (l2_req_o !== 2'b00) begin
            failures++;
            $display("FAIL rd_cycle0_req: got %b expected 00", l2_req_o);
        end
        cyc();
        l2_gnt_i[0] = 1'b1;
        #1;
        checks++;
        if (l2_req_o !== 2'b01 || l2_addr_o[63:0] !== 64'h10 || l2_we_o[0] !== 1'b0) begin
            failures++;
            $display("FAIL rd_req: req=%b addr=%h we=%b expected 01 10 0", l2_req_o, l2_addr_o[63:0], l2_we_o[0]);
        end
        checks++;
        if (req_ready_o !== 4'b0001) begin
            failures++;
            $display("FAIL rd_ready: got %b expected 0001", req_ready_o);
        end
        cyc();
        req_valid_i = '0;
        l2_gnt_i    = '0;
        cyc();
        l2_rvalid_i[0]     = 1'b1;
        l2_rdata_i[63:0]   = 64'hDEAD;
        #1;
        checks++;
        if (rsp_valid_o !== 4'd0 || req_ready_o !== 4'd0) begin
            failures++;
            $display("FAIL rd_early_rsp: rsp_valid=%b ready=%b expected 0", rsp_valid_o, req_ready_o);
        end
        cyc();
        l2_rvalid_i = '0;
        #1;
        checks++;
        if (rsp_valid_o !== 4'b0001 || rsp_rdata_o[63:0] !== 64'hDEAD || rsp_err_o !== 4'd0) begin
            failures++;
            $display("FAIL rd_rsp: valid=%b rdata=%h err=%b expected 0001 dead 0", rsp_valid_o, rsp_rdata_o[63:0], rsp_err_o);
        end
        cyc();
        checks++;
        if (rsp_valid_o !== 4'd0 || l2_req_o !== 2'b00) begin
            failures++;
            $display("FAIL rd_pulse: valid=%b l2_req=%b expected 0", rsp_valid_o, l2_req_o);
        end
    endtask

    task automatic test_parallel();
        do_reset();
        set_req(1, 64'h7820_0008, 1'b1, 64'h1234_5678);
        set_req(2, 64'h7800_0000, 1'b0, 64'd0);
        cyc();
        l2_gnt_i = 2'b11;
        #1;
        checks++;
        if (l2_req_o !== 2'b11 || l2_addr_o[127:64] !== 64'h8 || l2_addr_o[63:0] !== 64'h0) begin
            failures++;
            $display("FAIL par_addr: req=%b a1=%h a0=%h expected 11 8 0", l2_req_o, l2_addr_o[127:64], l2_addr_o[63:0]);
        end
        checks++;
        if (l2_we_o !== 2'b10 || l2_wdata_o[127:64] !== 64'h1234_5678) begin
            failures++;
            $display("FAIL par_we: we=%b wd1=%h expected 10 12345678", l2_we_o, l2_wdata_o[127:64]);
        end
        checks++;
        if (req_ready_o !== 4'b0110) begin
            failures++;
            $display("FAIL par_ready: got %b expected 0110", req_ready_o);
        end
        cyc();
        req_valid_i = '0;
        l2_gnt_i    = '0;
        cyc();
        l2_rvalid_i  = 2'b11;
        l2_rdata_i   = {64'h5555_5555_5555_5555, 64'hBEEF};
        cyc();
        l2_rvalid_i  = '0;
        #1;
        checks++;
        if (rsp_valid_o !== 4'b0110 || rsp_err_o !== 4'd0) begin
            failures++;
            $display("FAIL par_rsp_valid: valid=%b err=%b expected 0110 0", rsp_valid_o, rsp_err_o);
        end
        checks++;
        if (rsp_rdata_o[191:128] !== 64'hBEEF || rsp_rdata_o[127:64] !== 64'd0) begin
            failures++;
            $display("FAIL par_rsp_data: m2=%h m1=%h expected beef 0", rsp_rdata_o[191:128], rsp_rdata_o[127:64]);
        end
    endtask

    task automatic test_round_robin();
        int got[$];
        do_reset();
        for (int m = 0; m < 4; m++) set_req(m, P0 + 64'(m) * 64'h100, 1'b0, 64'd0);
        for (int c = 0; c < 100 && got.size() < 5; c++) begin
            auto_step();
            for (int m = 0; m < 4; m++) if (req_ready_o[m]) got.push_back(m);
        end
        checks++;
        if (got.size() < 5) begin
            failures++;
            $display("FAIL rr_timeout: got %0d grants expected 5", got.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got[i] != i % 4) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got master %0d expected %0d", i, got[i], i % 4);
                end
            end
        end
        req_valid_i = '0;
    endtask

    task automatic test_decode_err();
        logic [63:0] addrs [2];
        addrs[0] = 64'h7840_0000;
        addrs[1] = 64'h77FF_FFF8;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            set_req(3, addrs[k], 1'b0, 64'd0);
            #1;
            checks++;
            if (req_ready_o !== 4'd0) begin
                failures++;
                $display("FAIL err_ready_early[%0d]: got %b expected 0", k, req_ready_o);
            end
            cyc();
            checks++;
            if (req_ready_o !== 4'b1000 || l2_req_o !== 2'b00 || rsp_valid_o !== 4'd0) begin
                failures++;
                $display("FAIL err_accept[%0d]: ready=%b l2_req=%b rsp=%b expected 1000 00 0", k, req_ready_o, l2_req_o, rsp_valid_o);
            end
            req_valid_i = '0;
            cyc();
            checks++;
            if (rsp_valid_o !== 4'b1000 || rsp_err_o !== 4'b1000 || rsp_rdata_o[255:192] !== 64'd0 || l2_req_o !== 2'b00) begin
                failures++;
                $display("FAIL err_rsp[%0d]: valid=%b err=%b rdata=%h l2_req=%b expected 1000 1000 0 00", k, rsp_valid_o, rsp_err_o, rsp_rdata_o[255:192], l2_req_o);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1, 64'h7820_0040, 1'b0, 64'd0);
        cyc();
        l2_gnt_i[1] = 1'b1;
        set_req(0, 64'h7800_0040, 1'b0, 64'd0);
        #1;
        checks++;
        if (req_ready_o !== 4'b0010) begin
            failures++;
            $display("FAIL mid_ready: got %b expected 0010", req_ready_o);
        end
        cyc();
        l2_gnt_i       = '0;
        req_valid_i[1] = 1'b0;
        #1;
        checks++;
        if (l2_req_o !== 2'b01) begin
            failures++;
            $display("FAIL mid_pre: l2_req=%b expected 01", l2_req_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, l2_req_o, l2_we_o} !== 14'd0 || l2_addr_o !== '0) begin
            failures++;
            $display("FAIL mid_async: outputs %h expected 0", {req_ready_o, rsp_valid_o, rsp_err_o, l2_req_o, l2_we_o});
        end
        req_valid_i = '0;
        cyc();
        rst_i = 1'b0;
        cyc();
        l2_rvalid_i[1]       = 1'b1;
        l2_rdata_i[127:64]   = 64'hCAFE;
        cyc();
        l2_rvalid_i = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (rsp_valid_o !== 4'd0) begin
                failures++;
                $display("FAIL mid_stale_rsp[%0d]: got %b expected 0", c, rsp_valid_o);
            end
            cyc();
        end
    endtask

    task automatic test_random();
        logic [63:0] edges [6];
        logic [63:0] maddr [4];
        logic        mwe   [4];
        logic [63:0] mwd   [4];
        logic [63:0] exp_data [4][$];
        bit          exp_err  [4][$];
        bit          pend [2];
        int          dly  [2];
        logic [63:0] poff [2];
        logic        pwe  [2];
        int          n_rsp;
        int          n_rdy;
        bit          done;
        int          d;
        logic [63:0] off;
        int          k;
        edges[0] = P0 - 64'd8;
        edges[1] = PEND;
        edges[2] = P1 - 64'd8;
        edges[3] = P1;
        edges[4] = 64'd0;
        edges[5] = 64'hFFFF_FFFF_FFFF_FFF8;
        n_rsp = 0;
        done  = 1'b0;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0;
            dly[p]  = 0;
            poff[p] = '0;
            pwe[p]  = 1'b0;
        end
        for (int c = 0; c < 4000 && !done; c++) begin
            cyc();
            for (int p = 0; p < 2; p++) begin
                l2_rvalid_i[p]           = 1'b0;
                l2_rdata_i[p*64 +: 64]   = {$urandom, $urandom};
                l2_gnt_i[p]              = 1'b0;
                if (pend[p]) begin
                    if (dly[p] == 0) begin
                        l2_rvalid_i[p] = 1'b1;
                        if (!pwe[p]) l2_rdata_i[p*64 +: 64] = l2_word(p, poff[p]);
                        pend[p] = 1'b0;
                    end else begin
                        dly[p]--;
                    end
                end else if (l2_req_o[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        l2_gnt_i[p] = 1'b1;
                        pend[p]     = 1'b1;
                        dly[p]      = $urandom_range(0, 3);
                        poff[p]     = l2_addr_o[p*64 +: 64];
                        pwe[p]      = l2_we_o[p];
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    l2_rvalid_i[p] = 1'b1;
                end
            end
            #1;
            for (int m = 0; m < 4; m++) begin
                if (rsp_valid_o[m]) begin
                    checks++;
                    if (exp_data[m].size() == 0) begin
                        failures++;
                        $display("FAIL rand_spurious_rsp: master %0d got response, expected none", m);
                    end else begin
                        n_rsp++;
                        if (rsp_rdata_o[m*64 +: 64] !== exp_data[m][0] || rsp_err_o[m] !== exp_err[m][0]) begin
                            failures++;
                            $display("FAIL rand_rsp m%0d: rdata=%h err=%b expected %h %b", m, rsp_rdata_o[m*64 +: 64], rsp_err_o[m], exp_data[m][0], exp_err[m][0]);
                        end
                        void'(exp_data[m].pop_front());
                        void'(exp_err[m].pop_front());
                    end
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (l2_gnt_i[p]) begin
                    n_rdy = 0;
                    for (int m = 0; m < 4; m++) if (req_ready_o[m] && req_valid_i[m] && decode(maddr[m]) == p) n_rdy++;
                    checks++;
                    if (n_rdy != 1) begin
                        failures++;
                        $display("FAIL rand_gnt_ready p%0d: %0d masters readied, expected 1", p, n_rdy);
                    end
                end
            end
            for (int m = 0; m < 4; m++) begin
                if (req_ready_o[m]) begin
                    checks++;
                    if (!req_valid_i[m]) begin
                        failures++;
                        $display("FAIL rand_ready_no_valid: master %0d ready=1 expected 0", m);
                        continue;
                    end
                    d = decode(maddr[m]);
                    if (d == 2) begin
                        exp_data[m].push_back(64'd0);
                        exp_err[m].push_back(1'b1);
                    end else begin
                        off = maddr[m] - ((d == 0) ? P0 : P1);
                        if (!l2_gnt_i[d] || l2_addr_o[d*64 +: 64] !== off || l2_we_o[d] !== mwe[m]
                            || l2_wdata_o[d*64 +: 64] !== mwd[m]) begin
                            failures++;
                            $display("FAIL rand_route m%0d p%0d: gnt=%b addr=%h we=%b wd=%h expected 1 %h %b %h", m, d, l2_gnt_i[d], l2_addr_o[d*64 +: 64], l2_we_o[d], l2_wdata_o[d*64 +: 64], off, mwe[m], mwd[m]);
                        end
                        exp_data[m].push_back(mwe[m] ? 64'd0 : l2_word(d, off));
                        exp_err[m].push_back(1'b0);
                    end
                    req_valid_i[m] = 1'b0;
                end
            end
            for (int m = 0; m < 4; m++) begin
                if (!req_valid_i[m] && c < 3000 && $urandom_range(0, 2) == 0) begin
                    off = 64'($urandom_range(0, 262143)) << 3;
                    k   = $urandom_range(0, 9);
                    if (k < 4)       maddr[m] = P0 + off;
                    else if (k < 7)  maddr[m] = P1 + off;
                    else if (k == 7) maddr[m] = edges[$urandom_range(0, 5)];
                    else if (k == 8) maddr[m] = P0 - off - 64'd8;
                    else             maddr[m] = PEND + off;
                    mwe[m] = 1'($urandom_range(0, 1));
                    mwd[m] = {$urandom, $urandom};
                    set_req(m, maddr[m], mwe[m], mwd[m]);
                end
            end
            if (c >= 3000) begin
                done = (req_valid_i == 4'd0) && !pend[0] && !pend[1] && (l2_req_o == 2'b00);
                for (int m = 0; m < 4; m++) if (exp_data[m].size() != 0) done = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL rand_drain: traffic did not drain within budget");
        end
        checks++;
        if (n_rsp < 200) begin
            failures++;
            $display("FAIL rand_throughput: %0d responses, expected at least 200", n_rsp);
        end
        clear_inputs();
    endtask

`ifdef L2_ARB_PERF_CNT_EN
    task automatic test_perf();
        int grants;
        grants = 0;
        do_reset();
        set_req(0, P0 + 64'h80, 1'b0, 64'd0);
        for (int c = 0; c < 100 && grants < 5; c++) begin
            auto_step();
            if (req_ready_o[0]) grants++;
        end
        req_valid_i = '0;
        repeat (3) auto_step();
        for (int k = 0; k < 2; k++) begin
            set_req(3, PEND + 64'(k) * 64'h40, 1'b0, 64'd0);
            cyc();
            req_valid_i = '0;
            cyc();
            cyc();
        end
        #1;
        checks++;
        if (perf_grant_cnt_o[31:0] !== 32'd5 || perf_grant_cnt_o[63:32] !== 32'd0) begin
            failures++;
            $display("FAIL perf_grant: got %h expected p0=5 p1=0", perf_grant_cnt_o);
        end
        checks++;
        if (perf_err_cnt_o !== 32'd2) begin
            failures++;
            $display("FAIL perf_err: got %0d expected 2", perf_err_cnt_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_read();
        test_parallel();
        test_round_robin();
        test_decode_err();
        test_reset_mid();
        test_random();
`ifdef L2_ARB_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
